// File: rtl/temp_mon_pkg.sv
// temp_mon_pkg: shared types and constants for the multi-channel temperature
// abnormality monitor. Holds the per-channel FSM state encoding, the default
// thresholds and the width helpers used to size the datapath.
package temp_mon_pkg;

   // Per-channel persistence states. NORMAL is encoded as zero so a cleared
   // debug bus reads back as "every channel idle".
   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      SUSPECT = 2'd1,
      ALARM   = 2'd2,
      RECOVER = 2'd3
   } ch_state_e;

   localparam int DEF_LOW_TH  = 35;
   localparam int DEF_HIGH_TH = 39;
   localparam int DEF_PERSIST = 3;
   localparam int DEF_HYST    = 1;

   // Width that holds base + coef*sensor without overflow: the product needs
   // coef_w+sensor_w bits, and the sum adds one carry bit on top of the wider
   // of product and base.
   function automatic int sum_width(input int base_w, input int coef_w,
                                    input int sensor_w);
      int prod_w;
      prod_w = coef_w + sensor_w;
      return ((prod_w > base_w) ? prod_w : base_w) + 1;
   endfunction

   // Index width for n items, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/temp_ch_fsm.sv
// temp_ch_fsm: persistence state machine for a single channel. Counts
// consecutive abnormal samples before declaring an alarm and consecutive
// normal samples before releasing it, and keeps a sticky alarm flag that
// software clears. Only samples addressed to this channel advance it.
module temp_ch_fsm
   import temp_mon_pkg::*;
#(
   parameter int PERSIST = DEF_PERSIST
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       smp_valid_i,  // a sample for this channel is in stage 2
   input  logic       band_abn_i,   // sample lies outside the normal band
   input  logic       rec_abn_i,    // sample fails the recovery window
   input  logic       clear_i,      // clear pulse for the sticky flag
   output logic       alarm_o,
   output logic       latched_o,
   output logic [1:0] state_o
);

   localparam int CNT_W = idx_width(PERSIST + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(PERSIST);

   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             latched_q, latched_d;
   logic             enter_alarm;

   assign cnt_inc = cnt_q + CNT_ONE;

   // State, counter and sticky flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= NORMAL;
         cnt_q     <= '0;
         latched_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         latched_q <= latched_d;
      end
   end

   // Next-state logic: abnormal samples push toward ALARM, normal samples
   // (judged against the recovery window while alarmed) push back to NORMAL.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      enter_alarm = 1'b0;
      if (smp_valid_i) begin
         unique case (state_q)
            NORMAL: begin
               if (band_abn_i) begin
                  if (PERSIST == 1) begin
                     state_d     = ALARM;
                     cnt_d       = '0;
                     enter_alarm = 1'b1;
                  end else begin
                     state_d = SUSPECT;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            SUSPECT: begin
               if (band_abn_i) begin
                  if (cnt_inc == CNT_TOP) begin
                     state_d     = ALARM;
                     cnt_d       = '0;
                     enter_alarm = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d = NORMAL;
                  cnt_d   = '0;
               end
            end
            ALARM: begin
               if (!rec_abn_i) begin
                  if (PERSIST == 1) begin
                     state_d = NORMAL;
                     cnt_d   = '0;
                  end else begin
                     state_d = RECOVER;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            RECOVER: begin
               if (!rec_abn_i) begin
                  if (cnt_inc == CNT_TOP) begin
                     state_d = NORMAL;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d     = ALARM;
                  cnt_d       = '0;
                  enter_alarm = 1'b1;
               end
            end
            default: begin
               state_d = NORMAL;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Sticky flag: a new alarm entry beats a clear arriving in the same cycle.
   always_comb begin
      latched_d = latched_q;
      if (enter_alarm) begin
         latched_d = 1'b1;
      end else if (clear_i) begin
         latched_d = 1'b0;
      end
   end

   assign alarm_o   = (state_q == ALARM) || (state_q == RECOVER);
   assign latched_o = latched_q;
   assign state_o   = state_q;

endmodule

// File: rtl/temp_abnormality_monitor.sv
// temp_abnormality_monitor: multi-channel temperature abnormality monitor.
// Samples arrive time-multiplexed over a valid/ready port, are captured, turned
// into a saturated temperature, and then steer one persistence FSM per channel.
//
// Handshake: a sample transfers on a rising edge where sample_valid and
// sample_ready are both high; sample_ready is low only while rst is asserted,
// and the pipeline never back-pressures.
//
// Pipeline: capture at the acceptance edge N, temperature at N+1, FSM, alarm
// and ch_err at N+2. Channel state is touched only in the last stage, so
// back-to-back samples on one channel need no forwarding.
//
// Build option: define TEMP_HYST_EN to narrow the band by HYST on each side
// while a channel is alarmed, so recovery needs a clearly normal reading.
module temp_abnormality_monitor
   import temp_mon_pkg::*;
#(
   parameter int CH       = 4,
   parameter int SENSOR_W = 4,
   parameter int COEF_W   = 4,
   parameter int BASE_W   = 8,
   parameter int TEMP_W   = 10,
   parameter int LOW_TH   = DEF_LOW_TH,
   parameter int HIGH_TH  = DEF_HIGH_TH,
   parameter int PERSIST  = DEF_PERSIST,
   parameter int HYST     = DEF_HYST
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [BASE_W-1:0]        factoryBaseTemp,
   input  logic [COEF_W-1:0]        factoryTempCoef,
   input  logic                     sample_valid,
   output logic                     sample_ready,
   input  logic [idx_width(CH)-1:0] sample_ch,
   input  logic [SENSOR_W-1:0]      tempSensorValue,
   output logic                     temp_valid,
   output logic [TEMP_W-1:0]        temperature,
   output logic [idx_width(CH)-1:0] temp_ch,
   output logic [CH-1:0]            alarm,
   output logic [CH-1:0]            alarm_latched,
   input  logic [CH-1:0]            alarm_clear,
   output logic                     abnormal_any,
   output logic                     ch_err,
   output logic [2*CH-1:0]          dbg_state    // 2-bit ch_state_e per channel
);

   localparam int CH_W   = idx_width(CH);
   localparam int FULL_W = sum_width(BASE_W, COEF_W, SENSOR_W);

`ifdef TEMP_HYST_EN
   localparam int REC_LOW  = LOW_TH + HYST;
   localparam int REC_HIGH = HIGH_TH - HYST;
`else
   // Same band in every state; HYST is multiplied out so it has no effect
   // while staying referenced.
   localparam int REC_LOW  = LOW_TH + 0 * HYST;
   localparam int REC_HIGH = HIGH_TH - 0 * HYST;
`endif

   logic                accept;
   logic                cap_valid_q;
   logic [CH_W-1:0]     cap_ch_q;
   logic [SENSOR_W-1:0] cap_sens_q;
   logic [BASE_W-1:0]   cap_base_q;
   logic [COEF_W-1:0]   cap_coef_q;
   logic                cap_in_range;
   logic [FULL_W-1:0]   full_sum;
   logic [TEMP_W-1:0]   sat_temp;
   logic                tvalid_q;
   logic                err1_q;
   logic [TEMP_W-1:0]   temp_q;
   logic [CH_W-1:0]     tch_q;
   logic                ch_err_q;
   logic                band_abn;
   logic                rec_abn;

   assign sample_ready = ~rst;
   assign accept       = sample_valid & sample_ready;

   // Capture stage: latch the sample and the factory constants at acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_valid_q <= 1'b0;
         cap_ch_q    <= '0;
         cap_sens_q  <= '0;
         cap_base_q  <= '0;
         cap_coef_q  <= '0;
      end else begin
         cap_valid_q <= accept;
         if (accept) begin
            cap_ch_q   <= sample_ch;
            cap_sens_q <= tempSensorValue;
            cap_base_q <= factoryBaseTemp;
            cap_coef_q <= factoryTempCoef;
         end
      end
   end

   assign cap_in_range = (int'(cap_ch_q) < CH);
   assign full_sum     = FULL_W'(cap_base_q) + FULL_W'(cap_coef_q) * FULL_W'(cap_sens_q);

   // Clamp to the largest representable temperature when the sum is too wide.
   generate
      if (FULL_W > TEMP_W) begin : g_sat
         assign sat_temp = (|full_sum[FULL_W-1:TEMP_W]) ? {TEMP_W{1'b1}}
                                                          : full_sum[TEMP_W-1:0];
      end else begin : g_nosat
         assign sat_temp = TEMP_W'(full_sum);
      end
   endgenerate

   // Temperature stage: out-of-range channels are dropped and only flagged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tvalid_q <= 1'b0;
         err1_q   <= 1'b0;
         temp_q   <= '0;
         tch_q    <= '0;
      end else begin
         tvalid_q <= cap_valid_q & cap_in_range;
         err1_q   <= cap_valid_q & ~cap_in_range;
         if (cap_valid_q && cap_in_range) begin
            temp_q <= sat_temp;
            tch_q  <= cap_ch_q;
         end
      end
   end

   // Error pulse lines up with the FSM update of an in-range sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_err_q <= 1'b0;
      end else begin
         ch_err_q <= err1_q;
      end
   end

   assign band_abn = (int'(temp_q) < LOW_TH) || (int'(temp_q) > HIGH_TH);
   assign rec_abn  = (int'(temp_q) < REC_LOW) || (int'(temp_q) > REC_HIGH);

   generate
      for (genvar i = 0; i < CH; i++) begin : g_ch
         temp_ch_fsm #(
            .PERSIST(PERSIST)
         ) u_fsm (
            .clk        (clk),
            .rst        (rst),
            .smp_valid_i(tvalid_q && (tch_q == CH_W'(i))),
            .band_abn_i (band_abn),
            .rec_abn_i  (rec_abn),
            .clear_i    (alarm_clear[i]),
            .alarm_o    (alarm[i]),
            .latched_o  (alarm_latched[i]),
            .state_o    (dbg_state[2*i +: 2])
         );
      end
   endgenerate

   assign temp_valid   = tvalid_q;
   assign temperature  = temp_q;
   assign temp_ch      = tch_q;
   assign ch_err       = ch_err_q;
   assign abnormal_any = |alarm;

endmodule

// File: tb/tb_temp_abnormality_monitor.sv
// tb_temp_abnormality_monitor: directed and randomized stimulus against a
// per-channel reference model. CH=5 makes channel indices 5..7 representable
// and out of range; TEMP_W=8 lets the factory extremes reach saturation.
module tb_temp_abnormality_monitor;

   localparam int CH       = 5;
   localparam int SENSOR_W = 4;
   localparam int COEF_W   = 4;
   localparam int BASE_W   = 8;
   localparam int TEMP_W   = 8;
   localparam int LOW_TH   = 35;
   localparam int HIGH_TH  = 39;
   localparam int PERSIST  = 3;
   localparam int HYST     = 1;
   localparam int CH_W     = (CH > 1) ? $clog2(CH) : 1;
   localparam int TMAX     = (1 << TEMP_W) - 1;
`ifdef TEMP_HYST_EN
   localparam int RLOW  = LOW_TH + HYST;
   localparam int RHIGH = HIGH_TH - HYST;
`else
   localparam int RLOW  = LOW_TH;
   localparam int RHIGH = HIGH_TH;
`endif

   logic                clk;
   logic                rst;
   logic [BASE_W-1:0]   factoryBaseTemp;
   logic [COEF_W-1:0]   factoryTempCoef;
   logic                sample_valid;
   logic                sample_ready;
   logic [CH_W-1:0]     sample_ch;
   logic [SENSOR_W-1:0] tempSensorValue;
   logic                temp_valid;
   logic [TEMP_W-1:0]   temperature;
   logic [CH_W-1:0]     temp_ch;
   logic [CH-1:0]       alarm;
   logic [CH-1:0]       alarm_latched;
   logic [CH-1:0]       alarm_clear;
   logic                abnormal_any;
   logic                ch_err;
   logic [2*CH-1:0]     dbg_state;

   temp_abnormality_monitor #(
      .CH(CH), .SENSOR_W(SENSOR_W), .COEF_W(COEF_W), .BASE_W(BASE_W),
      .TEMP_W(TEMP_W), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH),
      .PERSIST(PERSIST), .HYST(HYST)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .factoryBaseTemp(factoryBaseTemp),
      .factoryTempCoef(factoryTempCoef),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .sample_ch      (sample_ch),
      .tempSensorValue(tempSensorValue),
      .temp_valid     (temp_valid),
      .temperature    (temperature),
      .temp_ch        (temp_ch),
      .alarm          (alarm),
      .alarm_latched  (alarm_latched),
      .alarm_clear    (alarm_clear),
      .abnormal_any   (abnormal_any),
      .ch_err         (ch_err),
      .dbg_state      (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   typedef struct { int due; int ch; int t; } smp_t;
   typedef struct { logic [CH-1:0] alarm; logic [CH-1:0] lat; logic err; } stat_t;

   smp_t  temp_q[$];   // expected temperature outputs
   smp_t  pend_q[$];   // accepted samples waiting to reach the channel logic
   stat_t stat_q[$];   // expected alarm/status view, one per cycle

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int cur_base = 0;
   int cur_coef = 0;

   // reference model: per channel, alarm status and length of the current
   // run of samples arguing against that status
   bit            m_alarm[CH];
   int            m_run[CH];
   logic [CH-1:0] m_lat;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   initial begin : model
      smp_t          p;
      stat_t         se;
      logic [CH-1:0] set_v;
      logic          err_now;
      int            t;
      bit            abn;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            for (int i = 0; i < CH; i++) begin
               m_alarm[i] = 1'b0;
               m_run[i]   = 0;
            end
            m_lat = '0;
            pend_q.delete();
            temp_q.delete();
            stat_q.delete();
            se.alarm = '0;
            se.lat   = '0;
            se.err   = 1'b0;
            stat_q.push_back(se);
         end else begin
            cyc++;
            set_v   = '0;
            err_now = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
               p = pend_q.pop_front();
               if (p.ch >= CH) begin
                  err_now = 1'b1;
               end else if (!m_alarm[p.ch]) begin
                  abn = (p.t < LOW_TH) || (p.t > HIGH_TH);
                  if (abn) begin
                     m_run[p.ch]++;
                     if (m_run[p.ch] == PERSIST) begin
                        m_alarm[p.ch] = 1'b1;
                        m_run[p.ch]   = 0;
                        set_v[p.ch]   = 1'b1;
                     end
                  end else begin
                     m_run[p.ch] = 0;
                  end
               end else begin
                  abn = (p.t < RLOW) || (p.t > RHIGH);
                  if (!abn) begin
                     m_run[p.ch]++;
                     if (m_run[p.ch] == PERSIST) begin
                        m_alarm[p.ch] = 1'b0;
                        m_run[p.ch]   = 0;
                     end
                  end else begin
                     // a broken recovery run re-enters the alarm
                     if (m_run[p.ch] != 0) set_v[p.ch] = 1'b1;
                     m_run[p.ch] = 0;
                  end
               end
            end
            m_lat = (m_lat & ~alarm_clear) | set_v;
            if (sample_valid) begin
               t = int'(factoryBaseTemp) + int'(factoryTempCoef) * int'(tempSensorValue);
               if (t > TMAX) t = TMAX;
               if (int'(sample_ch) < CH) temp_q.push_back('{cyc + 1, int'(sample_ch), t});
               pend_q.push_back('{cyc + 2, int'(sample_ch), t});
            end
            for (int i = 0; i < CH; i++) se.alarm[i] = m_alarm[i];
            se.lat = m_lat;
            se.err = err_now;
            stat_q.push_back(se);
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      stat_t s;
      smp_t  te;
      bit    exp_tv;
      forever begin
         @(negedge clk);
         chk("sample_ready", int'(sample_ready), int'(!rst));
         if (stat_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL status_queue @%0t: got empty expected an entry", $time);
         end else begin
            s = stat_q.pop_front();
            chk("alarm", int'(alarm), int'(s.alarm));
            chk("alarm_latched", int'(alarm_latched), int'(s.lat));
            chk("abnormal_any", int'(abnormal_any), int'(s.alarm != '0));
            chk("ch_err", int'(ch_err), int'(s.err));
         end
         exp_tv = (temp_q.size() > 0) && (temp_q[0].due == cyc);
         chk("temp_valid", int'(temp_valid), int'(exp_tv));
         if (exp_tv) begin
            te = temp_q.pop_front();
            if (temp_valid) begin
               chk("temperature", int'(temperature), te.t);
               chk("temp_ch", int'(temp_ch), te.ch);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input bit v, input int ch, input int sens, input int clr);
      @(negedge clk);
      sample_valid    = v;
      sample_ch       = CH_W'(ch);
      tempSensorValue = SENSOR_W'(sens);
      factoryBaseTemp = BASE_W'(cur_base);
      factoryTempCoef = COEF_W'(cur_coef);
      alarm_clear     = CH'(clr);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_temp_valid"}, int'(temp_valid), 0);
      chk({tag, "_temperature"}, int'(temperature), 0);
      chk({tag, "_temp_ch"}, int'(temp_ch), 0);
      chk({tag, "_alarm"}, int'(alarm), 0);
      chk({tag, "_alarm_latched"}, int'(alarm_latched), 0);
      chk({tag, "_abnormal_any"}, int'(abnormal_any), 0);
      chk({tag, "_ch_err"}, int'(ch_err), 0);
      chk({tag, "_sample_ready"}, int'(sample_ready), 0);
      chk({tag, "_dbg_state"}, int'(dbg_state), 0);
   endtask

   // Asynchronous reset between clock edges; outputs must clear at once.
   task automatic pulse_reset();
      @(posedge clk);
      #2;
      rst          = 1'b1;
      sample_valid = 1'b0;
      alarm_clear  = '0;
      #1;
      check_outputs_zero("mid_reset");
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin : driver
      int mode, ch, sens, clr;
      rst             = 1'b1;
      sample_valid    = 1'b0;
      sample_ch       = '0;
      tempSensorValue = '0;
      factoryBaseTemp = '0;
      factoryTempCoef = '0;
      alarm_clear     = '0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("por");
      #1;
      rst = 1'b0;

      // in-band readings on channel 0: temperature 36, no alarm
      cur_base = 20;
      cur_coef = 4;
      for (int i = 0; i < 3; i++) drive(1'b1, 0, 4, 0);
      idle(3);

      // three hot readings on channel 1 raise and latch its alarm
      for (int i = 0; i < 3; i++) drive(1'b1, 1, 6, 0);
      idle(3);

      // interrupted recovery, then a clean recovery; the flag stays set
      drive(1'b1, 1, 4, 0);
      drive(1'b1, 1, 6, 0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1, 4, 0);
      idle(3);
      drive(1'b0, 0, 0, 1 << 1);
      idle(2);

      // clear arriving on the same edge as a fresh alarm entry
      for (int i = 0; i < 3; i++) drive(1'b1, 1, 6, 0);
      drive(1'b0, 0, 0, 0);
      drive(1'b0, 0, 0, 1 << 1);
      idle(3);
      drive(1'b0, 0, 0, 1 << 1);
      idle(2);

      // saturating temperature, then out-of-range channels
      cur_base = 255;
      cur_coef = 15;
      drive(1'b1, 3, 15, 0);
      drive(1'b1, 5, 15, 0);
      drive(1'b1, 7, 2, 0);
      idle(3);

      // channel 0 into alarm, then readings at the band edge and mid-band
      cur_base = 20;
      cur_coef = 4;
      for (int i = 0; i < 3; i++) drive(1'b1, 0, 6, 0);
      cur_base = 27;
      for (int i = 0; i < 3; i++) drive(1'b1, 0, 3, 0);
      idle(2);
      cur_base = 25;
      for (int i = 0; i < 3; i++) drive(1'b1, 0, 3, 0);
      idle(3);

      // channel 2 two samples into a run, third in flight when reset hits
      cur_base = 20;
      cur_coef = 4;
      for (int i = 0; i < 3; i++) drive(1'b1, 2, 6, 0);
      drive(1'b0, 0, 0, 0);
      pulse_reset();
      for (int i = 0; i < 2; i++) drive(1'b1, 2, 6, 0);
      idle(4);

      // randomized traffic with one asynchronous reset in the middle
      for (int k = 0; k < 800; k++) begin
         if (k == 400) pulse_reset();
         mode = $urandom_range(0, 9);
         if (mode < 7) begin
            cur_base = $urandom_range(17, 24);
            cur_coef = 4;
            sens     = $urandom_range(3, 5);
         end else begin
            cur_base = $urandom_range(0, 255);
            cur_coef = $urandom_range(0, 15);
            sens     = $urandom_range(0, 15);
         end
         ch  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2);
         clr = ($urandom_range(0, 9) == 0) ? $urandom_range(0, (1 << CH) - 1) : 0;
         drive($urandom_range(0, 3) != 0, ch, sens, clr);
      end
      idle(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got no end of test expected finish before 1000000");
      $fatal(1, "watchdog expired");
   end

endmodule
